// File: rtl/fb_pkg.sv
// Shared widths and controller states for the fb_cpu memory responder.
package fb_pkg;
  localparam int FB_ADDRESS_WIDTH = 6;
  localparam int FB_DATA_WIDTH    = 10;

  typedef enum logic [1:0] {
    LOAD  = 2'd0,
    RUN   = 2'd1,
    CLEAR = 2'd2
  } fb_state_e;
endpackage

// File: rtl/fb_ram_core.sv
// Single-port synchronous RAM with registered read-before-write output.
module fb_ram_core #(
  parameter int AW    = 6,
  parameter int DW    = 10,
  parameter int DEPTH = 64
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] addr,
  input  logic [DW-1:0] wdata,
  output logic [DW-1:0] rdata
);
  logic [DW-1:0] mem [DEPTH];

  // No reset on the array or the read register: contents survive rst.
  always_ff @(posedge clk) begin
    if (we) mem[addr] <= wdata;
    rdata <= mem[addr];
  end
endmodule

// File: rtl/fb_mem_responder.sv
// Memory responder for fb_cpu: RAM owned by host (LOAD), CPU (RUN) or the clear sweep (CLEAR).
//
//  state | meaning
//  LOAD  | host owns RAM via valid/ready port, CPU held in reset
//  RUN   | CPU owns RAM, hold released
//  CLEAR | sweep writes zero to every word, one per cycle, then back to LOAD
module fb_mem_responder
  import fb_pkg::*;
#(
  parameter int ADDRESS_WIDTH = FB_ADDRESS_WIDTH,
  parameter int DATA_WIDTH    = FB_DATA_WIDTH,
  parameter int DEPTH         = 2 ** ADDRESS_WIDTH,
  parameter int IO_ADDR       = 63
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [ADDRESS_WIDTH-1:0] i_addr,
  input  logic                     i_we,
  input  logic [DATA_WIDTH-1:0]    i_wdata,
  output logic [DATA_WIDTH-1:0]    o_rdata,
  output logic                     o_cpu_hold,
  input  logic                     h_valid,
  output logic                     h_ready,
  input  logic                     h_we,
  input  logic [ADDRESS_WIDTH-1:0] h_addr,
  input  logic [DATA_WIDTH-1:0]    h_wdata,
  output logic                     h_rvalid,
  output logic [DATA_WIDTH-1:0]    h_rdata,
  input  logic                     h_start,
  input  logic                     h_stop,
  input  logic                     h_clear,
  output logic [DATA_WIDTH-1:0]    o_io
);
  localparam logic [ADDRESS_WIDTH-1:0] IO_A     = ADDRESS_WIDTH'(IO_ADDR);
  localparam logic [ADDRESS_WIDTH-1:0] LAST_A   = ADDRESS_WIDTH'(DEPTH - 1);

  fb_state_e                  state_q, state_d;
  logic [ADDRESS_WIDTH-1:0]   clr_cnt_q;
  logic                       hold_q;
  logic                       run_q;
  logic                       rvalid_q;
  logic [DATA_WIDTH-1:0]      hdata_q;
  logic [DATA_WIDTH-1:0]      io_q;

  logic [ADDRESS_WIDTH-1:0]   ram_addr;
  logic                       ram_we;
  logic [DATA_WIDTH-1:0]      ram_wdata;
  logic [DATA_WIDTH-1:0]      ram_q;
  logic                       host_rd;
  logic                       io_we;

  always_comb begin
    state_d   = state_q;
    ram_addr  = h_addr;
    ram_we    = 1'b0;
    ram_wdata = h_wdata;
    host_rd   = 1'b0;
    io_we     = 1'b0;
    case (state_q)
      LOAD: begin
        ram_we  = h_valid & h_we;
        host_rd = h_valid & ~h_we;
        io_we   = h_valid & h_we & (h_addr == IO_A);
        if (h_clear)      state_d = CLEAR;
        else if (h_start) state_d = RUN;
      end
      RUN: begin
        ram_addr  = i_addr;
        ram_we    = i_we;
        ram_wdata = i_wdata;
        io_we     = i_we & (i_addr == IO_A);
        if (h_stop) state_d = LOAD;
      end
      CLEAR: begin
        ram_addr  = clr_cnt_q;
        ram_we    = 1'b1;
        ram_wdata = '0;
        if (clr_cnt_q == LAST_A) state_d = LOAD;
      end
      default: state_d = LOAD;
    endcase
  end

  // Writes are suppressed while rst is low so an aborted sweep leaves the tail intact.
  fb_ram_core #(
    .AW   (ADDRESS_WIDTH),
    .DW   (DATA_WIDTH),
    .DEPTH(DEPTH)
  ) u_ram (
    .clk  (clk),
    .we   (ram_we & rst),
    .addr (ram_addr),
    .wdata(ram_wdata),
    .rdata(ram_q)
  );

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q   <= LOAD;
      clr_cnt_q <= '0;
      hold_q    <= 1'b1;
      run_q     <= 1'b0;
      rvalid_q  <= 1'b0;
      hdata_q   <= '0;
      io_q      <= '0;
    end else begin
      state_q   <= state_d;
      clr_cnt_q <= (state_q == CLEAR) ? clr_cnt_q + ADDRESS_WIDTH'(1) : '0;
      hold_q    <= (state_d != RUN);
      run_q     <= (state_q == RUN);
      rvalid_q  <= host_rd;
      if (rvalid_q) hdata_q <= ram_q;
      if (io_we)    io_q    <= ram_wdata;
    end
  end

  // RAM read register is shared; each consumer sees it only when it owned the port last cycle.
  assign o_rdata    = run_q ? ram_q : '0;
  assign h_rdata    = rvalid_q ? ram_q : hdata_q;
  assign h_rvalid   = rvalid_q;
  assign h_ready    = (state_q == LOAD);
  assign o_cpu_hold = hold_q;
  assign o_io       = io_q;
endmodule

// File: tb/tb_fb_mem_responder.sv
// Randomized bench for fb_mem_responder against a cycle-level behavioural model.
module tb_fb_mem_responder;
  localparam int M_LOAD  = 0;
  localparam int M_RUN   = 1;
  localparam int M_CLEAR = 2;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [5:0] i_addr = '0;
  logic       i_we = 1'b0;
  logic [9:0] i_wdata = '0;
  logic [9:0] o_rdata;
  logic       o_cpu_hold;
  logic       h_valid = 1'b0;
  logic       h_ready;
  logic       h_we = 1'b0;
  logic [5:0] h_addr = '0;
  logic [9:0] h_wdata = '0;
  logic       h_rvalid;
  logic [9:0] h_rdata;
  logic       h_start = 1'b0;
  logic       h_stop = 1'b0;
  logic       h_clear = 1'b0;
  logic [9:0] o_io;

  always #5 clk = ~clk;

  fb_mem_responder dut (
    .clk(clk), .rst(rst),
    .i_addr(i_addr), .i_we(i_we), .i_wdata(i_wdata), .o_rdata(o_rdata),
    .o_cpu_hold(o_cpu_hold),
    .h_valid(h_valid), .h_ready(h_ready), .h_we(h_we), .h_addr(h_addr),
    .h_wdata(h_wdata), .h_rvalid(h_rvalid), .h_rdata(h_rdata),
    .h_start(h_start), .h_stop(h_stop), .h_clear(h_clear), .o_io(o_io)
  );

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Behavioural model
  logic [9:0] m_mem [64];
  int         m_mode = M_LOAD;
  int         m_cnt  = 0;
  logic [9:0] m_io   = '0;
  logic       m_rv   = 1'b0;
  logic [9:0] m_hd   = '0;
  logic [9:0] m_ord  = '0;

  task automatic model_step();
    if (!rst) begin
      m_mode = M_LOAD; m_cnt = 0; m_io = '0; m_rv = 1'b0; m_hd = '0; m_ord = '0;
    end else begin
      m_rv  = 1'b0;
      m_ord = '0;
      case (m_mode)
        M_LOAD: begin
          if (h_valid) begin
            if (h_we) begin
              m_mem[h_addr] = h_wdata;
              if (h_addr == 6'd63) m_io = h_wdata;
            end else begin
              m_rv = 1'b1;
              m_hd = m_mem[h_addr];
            end
          end
          if (h_clear)      m_mode = M_CLEAR;
          else if (h_start) m_mode = M_RUN;
        end
        M_RUN: begin
          m_ord = m_mem[i_addr];
          if (i_we) begin
            m_mem[i_addr] = i_wdata;
            if (i_addr == 6'd63) m_io = i_wdata;
          end
          if (h_stop) m_mode = M_LOAD;
        end
        default: begin
          m_mem[m_cnt] = '0;
          m_cnt++;
          if (m_cnt == 64) begin m_cnt = 0; m_mode = M_LOAD; end
        end
      endcase
    end
  endtask

  task automatic tick();
    model_step();
    @(posedge clk);
    #1;
    chk_eq("h_ready",    32'(h_ready),    32'(m_mode == M_LOAD));
    chk_eq("o_cpu_hold", 32'(o_cpu_hold), 32'(m_mode != M_RUN));
    chk_eq("o_io",       32'(o_io),       32'(m_io));
    chk_eq("h_rvalid",   32'(h_rvalid),   32'(m_rv));
    chk_eq("h_rdata",    32'(h_rdata),    32'(m_hd));
    chk_eq("o_rdata",    32'(o_rdata),    32'(m_ord));
  endtask

  task automatic idle();
    h_valid = 1'b0; h_we = 1'b0; h_start = 1'b0; h_stop = 1'b0; h_clear = 1'b0;
    i_we = 1'b0;
  endtask

  task automatic host_wr(input logic [5:0] a, input logic [9:0] d);
    h_valid = 1'b1; h_we = 1'b1; h_addr = a; h_wdata = d;
    tick();
    idle();
  endtask

  task automatic host_rd(input logic [5:0] a);
    h_valid = 1'b1; h_we = 1'b0; h_addr = a;
    tick();
    idle();
  endtask

  int         clr_len;
  logic [9:0] prev_word;

  initial begin
    // Reset and idle state
    tick(); tick();
    chk_eq("rst_hold", 32'(o_cpu_hold), 32'd1);
    chk_eq("rst_ready", 32'(h_ready), 32'd1);
    chk_eq("rst_io", 32'(o_io), 32'd0);
    chk_eq("rst_rvalid", 32'(h_rvalid), 32'd0);
    rst = 1'b1;
    tick();

    // Define every word, then directed write/read of addr0
    for (int a = 0; a < 64; a++) host_wr(6'(a), 10'($urandom_range(1023)));
    host_wr(6'd0, 10'h032);
    host_rd(6'd0);
    chk_eq("rd0_valid", 32'(h_rvalid), 32'd1);
    chk_eq("rd0_data", 32'(h_rdata), 32'h032);
    tick();
    chk_eq("rd0_pulse", 32'(h_rvalid), 32'd0);

    // Full clear sweep
    host_wr(6'd10, 10'h3FF);
    h_clear = 1'b1; h_start = 1'b1;
    tick();
    idle();
    clr_len = 0;
    for (int k = 0; k < 100 && !h_ready; k++) begin
      clr_len++;
      h_valid = 1'b1; h_we = 1'b1; h_start = 1'b1;
      tick();
      idle();
    end
    chk_eq("clr_len", 32'(clr_len), 32'd64);
    host_rd(6'd0);  chk_eq("clr_a0",  32'(h_rdata), 32'd0);
    host_rd(6'd10); chk_eq("clr_a10", 32'(h_rdata), 32'd0);
    host_rd(6'd63); chk_eq("clr_a63", 32'(h_rdata), 32'd0);

    // Refill, then transfer together with h_start
    for (int a = 0; a < 64; a++) host_wr(6'(a), 10'($urandom_range(1023)));
    h_valid = 1'b1; h_we = 1'b0; h_addr = 6'd5; h_start = 1'b1;
    tick();
    idle();

    // IO write with read-before-write on the same address
    prev_word = m_mem[63];
    i_addr = 6'd63; i_we = 1'b1; i_wdata = 10'h02A;
    tick();
    idle();
    chk_eq("io_write", 32'(o_io), 32'h02A);
    chk_eq("io_rbw", 32'(o_rdata), 32'(prev_word));

    // Random CPU traffic
    for (int c = 0; c < 200; c++) begin
      i_addr  = ($urandom_range(3) == 0) ? 6'd63 : 6'($urandom_range(63));
      i_we    = 1'($urandom_range(1));
      i_wdata = 10'($urandom_range(1023));
      h_start = 1'($urandom_range(1));
      h_clear = 1'($urandom_range(1));
      tick();
    end
    i_we = 1'b1; i_addr = 6'd52; i_wdata = 10'd15; h_stop = 1'b1;
    tick();
    idle();
    host_rd(6'd52);
    chk_eq("stop_wr", 32'(h_rdata), 32'd15);

    // Random mixed traffic including resets and clears
    for (int c = 0; c < 600; c++) begin
      h_valid = 1'($urandom_range(1));
      h_we    = 1'($urandom_range(1));
      h_addr  = ($urandom_range(3) == 0) ? 6'd63 : 6'($urandom_range(63));
      h_wdata = 10'($urandom_range(1023));
      i_addr  = ($urandom_range(3) == 0) ? 6'd63 : 6'($urandom_range(63));
      i_we    = 1'($urandom_range(1));
      i_wdata = 10'($urandom_range(1023));
      h_start = ($urandom_range(15) == 0);
      h_stop  = ($urandom_range(15) == 0);
      h_clear = ($urandom_range(99) == 0);
      rst     = ($urandom_range(99) != 0);
      tick();
    end
    idle();
    rst = 1'b1;
    h_stop = 1'b1;
    for (int k = 0; k < 80; k++) tick();
    idle();

    // Reset on the 21st sweep cycle aborts the clear
    for (int a = 0; a < 64; a++) host_wr(6'(a), 10'h155);
    h_clear = 1'b1;
    tick();
    idle();
    for (int k = 0; k < 20; k++) tick();
    rst = 1'b0;
    tick();
    rst = 1'b1;
    chk_eq("abort_hold", 32'(o_cpu_hold), 32'd1);
    chk_eq("abort_ready", 32'(h_ready), 32'd1);
    for (int a = 0; a < 64; a++) begin
      host_rd(6'(a));
      chk_eq("abort_word", 32'(h_rdata), (a < 20) ? 32'd0 : 32'h155);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
